// File: rtl/fir_mac_engine.sv
// fir_mac_engine
//   Sequential multiply-accumulate FIR core. One accepted input sample produces
//   one filtered output. A single shared multiplier is stepped over all taps,
//   one tap per clock. Coefficients are written from the upstream register bank.
//   Results are handed back through a valid/ready handshake.
//
// Ports
//   ACLK       in   system clock, rising edge
//   ARESET     in   asynchronous active-high reset
//   coef_we    in   coefficient write strobe
//   coef_addr  in   coefficient index (tap k)
//   coef_data  in   signed coefficient h[k]
//   coef_err   out  one-cycle pulse: a coefficient write was dropped while busy
//   soft_clr   in   clears the delay line (only while idle)
//   x_valid    in   input sample valid
//   x_ready    out  engine can accept a sample (registered)
//   x_data     in   signed input sample
//   y_valid    out  result valid (registered)
//   y_ready    in   consumer accepts the result
//   y_data     out  signed filter output (registered)
//   busy       out  engine is not idle
module fir_mac_engine #(
  parameter int N_TAPS = 8,
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int ACC_W  = 19,
  parameter int AW     = $clog2(N_TAPS)
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              coef_we,
  input  logic [AW-1:0]     coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic              coef_err,
  input  logic              soft_clr,
  input  logic              x_valid,
  output logic              x_ready,
  input  logic [DATA_W-1:0] x_data,
  output logic              y_valid,
  input  logic              y_ready,
  output logic [ACC_W-1:0]  y_data,
  output logic              busy
);

  localparam int PW = DATA_W + COEF_W;
  localparam logic [AW-1:0] K_LAST   = AW'(N_TAPS - 1);
  localparam logic [AW:0]   N_TAPS_W = (AW + 1)'(N_TAPS);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t             state_reg, state_next;
  logic               x_ready_reg, x_ready_next;
  logic               y_valid_reg, y_valid_next;
  logic [ACC_W-1:0]   y_data_reg, y_data_next;
  logic [ACC_W-1:0]   acc_reg, acc_next;
  logic [AW-1:0]      k_reg, k_next;
  logic               coef_err_reg, coef_err_next;
  logic               accept;
  logic               idle_clr;
  logic               addr_ok;
  logic               coef_wr;

  logic [DATA_W-1:0]  x_reg [N_TAPS];
  logic [COEF_W-1:0]  h_reg [N_TAPS];

  logic [DATA_W-1:0]        x_sel;
  logic [COEF_W-1:0]        h_sel;
  logic signed [PW-1:0]     x_ext;
  logic signed [PW-1:0]     h_ext;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic [ACC_W-1:0]         sum;

  // Shared multiplier: operands are sign-extended to the full product width,
  // so the PW-bit product is exact; it is then sign-extended to ACC_W.
  assign x_sel    = x_reg[k_reg];
  assign h_sel    = h_reg[k_reg];
  assign x_ext    = PW'($signed(x_sel));
  assign h_ext    = PW'($signed(h_sel));
  assign prod     = x_ext * h_ext;
  assign prod_ext = ACC_W'(prod);
  assign sum      = acc_reg + prod_ext;

  assign idle_clr = (state_reg == IDLE) && soft_clr;

  // Out-of-range addresses are silently ignored, neither written nor flagged.
  assign addr_ok       = ({1'b0, coef_addr} < N_TAPS_W);
  assign coef_wr       = coef_we && addr_ok && (state_reg == IDLE);
  assign coef_err_next = coef_we && addr_ok && (state_reg != IDLE);

  always_comb begin
    state_next   = state_reg;
    x_ready_next = x_ready_reg;
    y_valid_next = y_valid_reg;
    y_data_next  = y_data_reg;
    acc_next     = acc_reg;
    k_next       = k_reg;
    accept       = 1'b0;
    case (state_reg)
      IDLE: begin
        // x_ready comes up on the first edge spent in IDLE (including after reset).
        x_ready_next = 1'b1;
        if (x_valid && x_ready_reg) begin
          accept       = 1'b1;
          x_ready_next = 1'b0;
          acc_next     = '0;
          k_next       = '0;
          state_next   = MAC;
        end
      end
      MAC: begin
        acc_next = sum;
        k_next   = k_reg + AW'(1);
        if (k_reg == K_LAST) begin
          y_data_next  = sum;
          y_valid_next = 1'b1;
          k_next       = '0;
          state_next   = OUT;
        end
      end
      OUT: begin
        if (y_valid_reg && y_ready) begin
          y_valid_next = 1'b0;
          x_ready_next = 1'b1;
          state_next   = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_reg    <= IDLE;
      x_ready_reg  <= 1'b0;
      y_valid_reg  <= 1'b0;
      y_data_reg   <= '0;
      acc_reg      <= '0;
      k_reg        <= '0;
      coef_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      x_ready_reg  <= x_ready_next;
      y_valid_reg  <= y_valid_next;
      y_data_reg   <= y_data_next;
      acc_reg      <= acc_next;
      k_reg        <= k_next;
      coef_err_reg <= coef_err_next;
    end
  end

  // Delay line. Tap 0 takes the new sample even when soft_clr coincides with
  // the accept; every older tap is cleared in that case.
  generate
    for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_tap
      if (gi == 0) begin : g_head
        always_ff @(posedge ACLK or posedge ARESET) begin
          if (ARESET) begin
            x_reg[gi] <= '0;
          end else if (accept) begin
            x_reg[gi] <= x_data;
          end else if (idle_clr) begin
            x_reg[gi] <= '0;
          end
        end
      end else begin : g_body
        always_ff @(posedge ACLK or posedge ARESET) begin
          if (ARESET) begin
            x_reg[gi] <= '0;
          end else if (idle_clr) begin
            x_reg[gi] <= '0;
          end else if (accept) begin
            x_reg[gi] <= x_reg[gi-1];
          end
        end
      end

      always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
          h_reg[gi] <= '0;
        end else if (coef_wr && (coef_addr == AW'(gi))) begin
          h_reg[gi] <= coef_data;
        end
      end
    end
  endgenerate

  assign x_ready  = x_ready_reg;
  assign y_valid  = y_valid_reg;
  assign y_data   = y_data_reg;
  assign coef_err = coef_err_reg;
  assign busy     = (state_reg != IDLE);

endmodule
